// File: rtl/alu_seq_exec.sv
// Execution-stage ALU with a valid/ready handshake. Single-cycle logic, arithmetic,
// compare and branch ops; shifts iterate one bit per clock instead of using a barrel shifter.
module alu_seq_exec #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  BrFlag
);
    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_XOR = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OR  = 4'b0011,
        OP_ADD = 4'b0100,
        OP_BGE = 4'b0101,
        OP_BNE = 4'b0110,
        OP_SRA = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_SLL = 4'b1001,
        OP_LUI = 4'b1010,
        OP_SRL = 4'b1100,
        OP_BLT = 4'b1101,
        OP_SLT = 4'b1110
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    op_t                     r_op;
    op_t                     w_op;
    logic [SHW-1:0]          r_cnt;
    logic [SHW-1:0]          w_shamt;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_brflag;
    logic [DATA_WIDTH-1:0]   w_alu_result;
    logic                    w_alu_br;
    logic [DATA_WIDTH-1:0]   w_shift_next;
    logic                    w_lt;
    logic                    w_ge;
    logic                    w_eq;
    logic                    w_ne;
    logic                    w_is_shift;
    logic                    w_accept;
    logic                    w_start_shift;
    logic                    w_shift_last;

    assign w_op          = op_t'(Operation);
    assign w_shamt       = B[SHW-1:0];
    assign w_lt          = $signed(A) < $signed(B);
    assign w_ge          = !w_lt;
    assign w_eq          = (A == B);
    assign w_ne          = !w_eq;
    assign w_is_shift    = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);
    assign w_accept      = in_valid && (r_state == ST_IDLE);
    assign w_start_shift = w_accept && w_is_shift && (w_shamt != '0);
    assign w_shift_last  = (r_cnt == SHW'(1));

    assign Result = r_result;
    assign BrFlag = r_brflag;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_alu_result = '0;
        w_alu_br     = 1'b0;
        case (w_op)
            OP_AND: w_alu_result = A & B;
            OP_XOR: w_alu_result = A ^ B;
            OP_SUB: w_alu_result = A - B;
            OP_OR:  w_alu_result = A | B;
            OP_ADD: w_alu_result = A + B;
            OP_LUI: w_alu_result = B;
            OP_SLT: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            OP_BGE: begin w_alu_br = w_ge; w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_ge}; end
            OP_BNE: begin w_alu_br = w_ne; w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_ne}; end
            OP_BEQ: begin w_alu_br = w_eq; w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_eq}; end
            OP_BLT: begin w_alu_br = w_lt; w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_lt}; end
            // A shift that reaches here has a zero amount, so the operand passes through.
            OP_SLL, OP_SRL, OP_SRA: w_alu_result = A;
            default: ;
        endcase
    end

    always_comb begin
        w_shift_next = r_result;
        case (r_op)
            OP_SLL:  w_shift_next = {r_result[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  w_shift_next = {1'b0, r_result[DATA_WIDTH-1:1]};
            OP_SRA:  w_shift_next = {r_result[DATA_WIDTH-1], r_result[DATA_WIDTH-1:1]};
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = w_start_shift ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: if (w_shift_last) w_state_next = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // The result register doubles as the shift register while in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_brflag <= 1'b0;
            r_cnt    <= '0;
            r_op     <= OP_AND;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= w_op;
                        if (w_start_shift) begin
                            r_result <= A;
                            r_brflag <= 1'b0;
                            r_cnt    <= w_shamt;
                        end else begin
                            r_result <= w_alu_result;
                            r_brflag <= w_alu_br;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_result <= w_shift_next;
                    r_cnt    <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_seq_exec;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        BrFlag;

    int vectors;
    int miscompares;

    alu_seq_exec #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .BrFlag    (BrFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extra = edges after the accept edge until out_valid is seen.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic br, output int extra);
        int n;
        logic lt;
        n     = int'(b[4:0]);
        lt    = $signed(a) < $signed(b);
        r     = 32'h0;
        br    = 1'b0;
        extra = 0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a ^ b;
            4'b0010: r = a - b;
            4'b0011: r = a | b;
            4'b0100: r = a + b;
            4'b0101: br = !lt;
            4'b0110: br = (a != b);
            4'b0111: begin r = $signed(a) >>> n; extra = n; end
            4'b1000: br = (a == b);
            4'b1001: begin r = a << n; extra = n; end
            4'b1010: r = b;
            4'b1100: begin r = a >> n; extra = n; end
            4'b1101: br = lt;
            4'b1110: r = {31'h0, lt};
            default: r = 32'h0;
        endcase
        if (op == 4'b0101 || op == 4'b0110 || op == 4'b1000 || op == 4'b1101) r = {31'h0, br};
    endfunction

    // Issues one op with out_ready high; returns what the DUT produced.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic rdy, output logic [31:0] res, output logic br,
                          output int extra, output logic handoff_ok);
        @(negedge clk);
        rdy       = in_ready;
        Operation = op;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        Operation = 4'($urandom);
        A         = $urandom;
        B         = $urandom;
        extra     = 0;
        while (out_valid !== 1'b1 && extra < 64) begin
            @(negedge clk);
            extra++;
        end
        res = Result;
        br  = BrFlag;
        @(negedge clk);
        handoff_ok = (out_valid === 1'b0) && (in_ready === 1'b1);
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Operation = 4'h0;
        A         = 32'h0;
        B         = 32'h0;
        repeat (2) @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        vectors++; if (Result !== 32'h0) begin miscompares++; $display("FAIL reset Result: got %h want 0", Result); end
        vectors++; if (BrFlag !== 1'b0) begin miscompares++; $display("FAIL reset BrFlag: got %b want 0", BrFlag); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
    endtask

    // Directed table runner: each row's expectations are written as constants.
    task automatic run_table(input string tag, input logic [3:0] ops[], input logic [31:0] as[],
                             input logic [31:0] bs[], input logic [31:0] exp_r[],
                             input logic exp_b[], input int exp_x[]);
        logic rdy, br, hok;
        logic [31:0] res;
        int x;
        foreach (ops[i]) begin
            run_op(ops[i], as[i], bs[i], rdy, res, br, x, hok);
            vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL %s[%0d] in_ready: got %b want 1", tag, i, rdy); end
            vectors++; if (res !== exp_r[i]) begin miscompares++; $display("FAIL %s[%0d] Result: got %h want %h", tag, i, res, exp_r[i]); end
            vectors++; if (br !== exp_b[i]) begin miscompares++; $display("FAIL %s[%0d] BrFlag: got %b want %b", tag, i, br, exp_b[i]); end
            vectors++; if (x != exp_x[i]) begin miscompares++; $display("FAIL %s[%0d] latency: got %0d want %0d", tag, i, x, exp_x[i]); end
            vectors++; if (hok !== 1'b1) begin miscompares++; $display("FAIL %s[%0d] handoff: got %b want 1", tag, i, hok); end
        end
    endtask

    task automatic test_arith;
        logic [3:0]  ops[]   = '{4'b0100, 4'b0010, 4'b0000, 4'b0011, 4'b0001};
        logic [31:0] as[]    = '{32'h7FFFFFFF, 32'h0, 32'hFF00FF00, 32'hF0000000, 32'hAAAA5555};
        logic [31:0] bs[]    = '{32'h1, 32'h1, 32'h0FF00FF0, 32'h0000000F, 32'hFFFF0000};
        logic [31:0] exp_r[] = '{32'h80000000, 32'hFFFFFFFF, 32'h0F000F00, 32'hF000000F, 32'h55555555};
        logic        exp_b[] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int          exp_x[] = '{0, 0, 0, 0, 0};
        run_table("arith", ops, as, bs, exp_r, exp_b, exp_x);
    endtask

    task automatic test_shift;
        logic [3:0]  ops[]   = '{4'b0111, 4'b1001, 4'b1100, 4'b1001};
        logic [31:0] as[]    = '{32'h80000000, 32'h1, 32'h80000000, 32'h00000003};
        logic [31:0] bs[]    = '{32'd31, 32'd0, 32'd4, 32'hFFFFFFE1};
        logic [31:0] exp_r[] = '{32'hFFFFFFFF, 32'h1, 32'h08000000, 32'h00000006};
        logic        exp_b[] = '{1'b0, 1'b0, 1'b0, 1'b0};
        int          exp_x[] = '{31, 0, 4, 1};
        run_table("shift", ops, as, bs, exp_r, exp_b, exp_x);
    endtask

    task automatic test_branch;
        logic [3:0]  ops[]   = '{4'b1101, 4'b0101, 4'b1000, 4'b0110, 4'b1110, 4'b1010};
        logic [31:0] as[]    = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hDEADBEEF};
        logic [31:0] bs[]    = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h12345000};
        logic [31:0] exp_r[] = '{32'h1, 32'h0, 32'h0, 32'h1, 32'h1, 32'h12345000};
        logic        exp_b[] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          exp_x[] = '{0, 0, 0, 0, 0, 0};
        run_table("branch", ops, as, bs, exp_r, exp_b, exp_x);
    endtask

    task automatic test_illegal;
        logic [3:0]  ops[]   = '{4'b1011, 4'b1111, 4'b1011};
        logic [31:0] as[]    = '{32'hFFFFFFFF, 32'h12345678, 32'h1};
        logic [31:0] bs[]    = '{32'hFFFFFFFF, 32'h9ABCDEF0, 32'h1};
        logic [31:0] exp_r[] = '{32'h0, 32'h0, 32'h0};
        logic        exp_b[] = '{1'b0, 1'b0, 1'b0};
        int          exp_x[] = '{0, 0, 0};
        run_table("illegal", ops, as, bs, exp_r, exp_b, exp_x);
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_r;
        int x;
        @(negedge clk);
        Operation = 4'b0100;
        A         = $urandom;
        B         = $urandom;
        exp_r     = A + B;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x = 0;
        while (out_valid !== 1'b1 && x < 64) begin @(negedge clk); x++; end
        vectors++; if (x != 0) begin miscompares++; $display("FAIL bp latency: got %0d want 0", x); end
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            Operation = 4'b0010;
            A         = $urandom;
            B         = $urandom;
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp in_ready c%0d: got %b want 0", c, in_ready); end
            @(posedge clk);
            @(negedge clk);
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp out_valid c%0d: got %b want 1", c, out_valid); end
            vectors++; if (Result !== exp_r) begin miscompares++; $display("FAIL bp Result c%0d: got %h want %h", c, Result, exp_r); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp handoff: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp ignored request: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_midshift;
        logic rdy, br, hok;
        logic [31:0] res;
        int x;
        @(negedge clk);
        Operation = 4'b1001;
        A         = $urandom | 32'h1;
        B         = 32'd20;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midshift out_valid: got %b want 0", out_valid); end
        rst_n = 1'b0;
        #1;
        vectors++; if (Result !== 32'h0) begin miscompares++; $display("FAIL midshift reset Result: got %h want 0", Result); end
        vectors++; if (BrFlag !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL midshift reset flags: got br=%b valid=%b want 0/0", BrFlag, out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midshift reset in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b0001, 32'hF0F0F0F0, 32'hFFFF0000, rdy, res, br, x, hok);
        vectors++; if (res !== 32'h0F0FF0F0 || x != 0 || hok !== 1'b1) begin miscompares++; $display("FAIL post-reset XOR: got %h lat=%0d hok=%b want 0f0ff0f0 lat=0 hok=1", res, x, hok); end
    endtask

    task automatic test_random;
        logic rdy, br, hok, exp_b;
        logic [31:0] res, a, b, exp_r;
        logic [3:0] op;
        int x, exp_x;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            model(op, a, b, exp_r, exp_b, exp_x);
            run_op(op, a, b, rdy, res, br, x, hok);
            vectors++;
            if (res !== exp_r || br !== exp_b || x != exp_x || hok !== 1'b1 || rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: got r=%h br=%b lat=%0d hok=%b rdy=%b want r=%h br=%b lat=%0d hok=1 rdy=1",
                         i, op, a, b, res, br, x, hok, rdy, exp_r, exp_b, exp_x);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_arith();
        test_shift();
        test_branch();
        test_illegal();
        test_backpressure();
        test_reset_midshift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
